// File: rtl/sram_port_responder.sv
// sram_port_responder
// Memory-side responder for one filter command port. It holds a synchronous
// word-addressed RAM, accepts read/write commands under a registered ready
// handshake, and returns read data with a fixed-latency tagged strobe.
// It also provides a stall input to inject back-pressure.

module sram_port_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 4,
  parameter int DEPTH_LOG2    = 16,
  parameter int READ_LATENCY  = 3   // legal range 1..8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reflesh,
  input  logic                     stall,
  input  logic                     request,
  input  logic                     command_entry,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [TAG_WIDTH-1:0]     tag,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     ready,
  output logic                     valid,
  output logic [DATA_WIDTH-1:0]    query,
  output logic [TAG_WIDTH-1:0]     qtag,
  output logic [31:0]              read_count,
  output logic [31:0]              write_count,
  output logic                     protocol_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Ready handshake states. HOLD and IDLE both drive ready low; HOLD only
  // records that the initiator is still requesting while stalled.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } ready_state_e;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic                  vld;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } ret_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  ready_state_e state_q, state_d;

  logic                  accept;
  logic                  accept_rd;
  logic                  accept_wr;
  logic [DEPTH_LOG2-1:0] index;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  s0_vld_q, s0_vld_d;
  logic [TAG_WIDTH-1:0]  s0_tag_q, s0_tag_d;

  ret_t head;
  ret_t chain  [READ_LATENCY];
  ret_t pipe_q [READ_LATENCY];
  ret_t pipe_d [READ_LATENCY];

  logic [31:0] read_count_q,  read_count_d;
  logic [31:0] write_count_q, write_count_d;
  logic        protocol_error_q, protocol_error_d;

  // Upper address bits are deliberately ignored so addresses wrap.
  generate
    if (ADDRESS_WIDTH > DEPTH_LOG2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[ADDRESS_WIDTH-1:DEPTH_LOG2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  assign ready     = (state_q == ST_GRANT);
  // A command arriving together with reset/reflesh is dropped, even if the
  // registered ready is still high in that cycle.
  assign accept    = command_entry & ready & ~reset & ~reflesh;
  assign accept_wr = accept &  write_enable;
  assign accept_rd = accept & ~write_enable;
  assign index     = address[DEPTH_LOG2-1:0];

  // Ready state machine: next state from request/stall, reflesh forces IDLE.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    if (reflesh) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (request && !stall) state_d = ST_GRANT;
        ST_GRANT: begin
          if (!request)   state_d = ST_IDLE;
          else if (stall) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (!request)    state_d = ST_IDLE;
          else if (!stall) state_d = ST_GRANT;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM: write on accept, registered read into the pipeline head
  // ---------------------------------------------------------------------------
  // RAM array and its read register; contents survive reset and reflesh.
  always_ff @(posedge clock) begin
    // NOTE: the RAM is intentionally not reset; a reset loop over the array
    // would prevent mapping onto block RAM and contents must survive reflesh.
    if (accept_wr) ram[index] <= data_in;
    if (accept_rd) rd_data_q  <= ram[index];
  end

  // Head stage: valid and tag travelling alongside the RAM read register.
  always_comb begin
    s0_vld_d = accept_rd;
    s0_tag_d = accept_rd ? tag : s0_tag_q;
  end

  assign head = '{vld: s0_vld_q, tag: s0_tag_q, data: rd_data_q};

  // Source of each pipeline stage: the head for stage 0, else the previous stage.
  always_comb begin
    chain[0] = head;
    for (int i = 1; i < READ_LATENCY; i++) begin
      chain[i] = pipe_q[i-1];
    end
  end

  // Shift pipeline. Data/tag only move with a valid entry, so the last stage
  // keeps the last returned values while valid is low.
  always_comb begin
    pipe_d = pipe_q;
    for (int i = 0; i < READ_LATENCY; i++) begin
      pipe_d[i].vld = chain[i].vld;
      if (chain[i].vld) begin
        pipe_d[i].tag  = chain[i].tag;
        pipe_d[i].data = chain[i].data;
      end
    end
    if (reflesh) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_d[i] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky error
  // ---------------------------------------------------------------------------
  // Accepted-command counters (wrap mod 2**32) and rejected-command flag.
  always_comb begin
    read_count_d     = read_count_q  + {31'd0, accept_rd};
    write_count_d    = write_count_q + {31'd0, accept_wr};
    protocol_error_d = protocol_error_q | (command_entry & ~ready);
    if (reflesh) begin
      read_count_d     = '0;
      write_count_d    = '0;
      protocol_error_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // All control state with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q          <= ST_IDLE;
      s0_vld_q         <= 1'b0;
      s0_tag_q         <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      read_count_q     <= '0;
      write_count_q    <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      s0_vld_q         <= s0_vld_d;
      s0_tag_q         <= s0_tag_d;
      pipe_q           <= pipe_d;
      read_count_q     <= read_count_d;
      write_count_q    <= write_count_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign valid          = pipe_q[READ_LATENCY-1].vld;
  assign query          = pipe_q[READ_LATENCY-1].data;
  assign qtag           = pipe_q[READ_LATENCY-1].tag;
  assign read_count     = read_count_q;
  assign write_count    = write_count_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_sram_port_responder.sv
// Self-checking bench for sram_port_responder: directed steps followed by a
// randomized phase, all compared against a queue-based reference model.

module tb_sram_port_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int DL = 4;
  localparam int RL = 3;

  logic          clock = 1'b0;
  logic          reset, reflesh, stall, request, command_entry, write_enable;
  logic [AW-1:0] address;
  logic [TW-1:0] tag;
  logic [DW-1:0] data_in;
  logic          ready, valid, protocol_error;
  logic [DW-1:0] query;
  logic [TW-1:0] qtag;
  logic [31:0]   read_count, write_count;

  always #5 clock = ~clock;

  sram_port_responder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .DEPTH_LOG2(DL), .READ_LATENCY(RL)
  ) dut (
    .clock(clock), .reset(reset), .reflesh(reflesh), .stall(stall),
    .request(request), .command_entry(command_entry),
    .write_enable(write_enable), .address(address), .tag(tag),
    .data_in(data_in), .ready(ready), .valid(valid), .query(query),
    .qtag(qtag), .read_count(read_count), .write_count(write_count),
    .protocol_error(protocol_error)
  );

  // Reference model: RAM contents, pending returns with their due edge,
  // and the expected visible outputs.
  typedef struct {
    int unsigned   due;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] m_ram [1 << DL];
  ret_t          m_q [$];
  int unsigned   edge_n;
  bit            m_ready, m_valid, m_perr;
  logic [DW-1:0] m_query;
  logic [TW-1:0] m_qtag;
  logic [31:0]   m_rc, m_wc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h, expected %0h", name, edge_n, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare current outputs with the model,
  // advance the model by the rules, then let the edge happen.
  task automatic step(input bit rst, input bit rfl, input bit req, input bit stl,
                      input bit ce, input bit we, input logic [31:0] a,
                      input logic [TW-1:0] tg, input logic [31:0] din,
                      input bit chk = 1'b1);
    reset = rst; reflesh = rfl; request = req; stall = stl;
    command_entry = ce; write_enable = we; address = a; tag = tg; data_in = din;
    if (chk) begin
      check("ready",          {31'd0, ready},          {31'd0, m_ready});
      check("valid",          {31'd0, valid},          {31'd0, m_valid});
      check("query",          query,                   m_query);
      check("qtag",           {28'd0, qtag},           {28'd0, m_qtag});
      check("read_count",     read_count,              m_rc);
      check("write_count",    write_count,             m_wc);
      check("protocol_error", {31'd0, protocol_error}, {31'd0, m_perr});
    end
    if (rst || rfl) begin
      m_q.delete();
      m_rc = 0; m_wc = 0; m_perr = 1'b0; m_query = '0; m_qtag = '0;
    end else if (ce) begin
      if (!m_ready) begin
        m_perr = 1'b1;
      end else if (we) begin
        m_ram[a[DL-1:0]] = din;
        m_wc = m_wc + 1;
      end else begin
        m_q.push_back('{due: edge_n + 1 + RL, tag: tg, data: m_ram[a[DL-1:0]]});
        m_rc = m_rc + 1;
      end
    end
    m_ready = req && !stl && !rst && !rfl;
    @(posedge clock);
    #1;
    edge_n++;
    m_valid = 1'b0;
    if (m_q.size() > 0 && m_q[0].due == edge_n) begin
      m_valid = 1'b1;
      m_query = m_q[0].data;
      m_qtag  = m_q[0].tag;
      void'(m_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(0, 0, 1, 0, 1, 1, a, 0, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [TW-1:0] t);
    step(0, 0, 1, 0, 1, 0, a, t, 0);
  endtask

  initial begin
    edge_n = 0;
    m_ready = 1'b0; m_valid = 1'b0; m_perr = 1'b0;
    m_query = '0; m_qtag = '0; m_rc = 0; m_wc = 0;
    reset = 1'b1; reflesh = 1'b0; stall = 1'b0; request = 1'b0;
    command_entry = 1'b0; write_enable = 1'b0; address = '0; tag = '0; data_in = '0;
    #1;

    // Reset for two cycles with request held high; ready registers afterwards.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Preload every word (value = 100 + address).
    for (int i = 0; i < (1 << DL); i++) wr(i, 100 + i);

    // Write then read on the next cycle.
    wr(5, 32'hDEAD_BEEF);
    rd(5, 1);
    idle(RL + 2);

    // Streaming reads of 0..7 with alternating tags.
    for (int i = 0; i < 8; i++) rd(i, (i % 2 == 0) ? 4'd1 : 4'd2);
    idle(RL + 2);

    // Back-pressure mid-stream: stall for two cycles while still commanding.
    rd(0, 1);
    rd(1, 2);
    step(0, 0, 1, 1, 1, 0, 2, 1, 0);
    step(0, 0, 1, 1, 1, 0, 3, 2, 0);
    step(0, 0, 1, 0, 1, 0, 4, 1, 0);
    rd(5, 2);
    rd(6, 1);
    idle(RL + 2);

    // Address wrap: 0x13 aliases 0x3.
    wr(32'h13, 32'h11);
    rd(32'h3, 7);
    rd(32'hFFFF_FFF3, 0);
    idle(RL + 2);

    // reflesh with reads in flight: no returns, counters cleared, RAM kept.
    rd(1, 3);
    rd(3, 4);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(RL + 3);
    rd(3, 5);
    idle(RL + 2);

    // Request drop with a read in flight: the return still completes.
    rd(9, 6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 9, 0, 32'h5555);
    idle(RL + 2);

    // Randomized traffic with occasional reflesh/reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 127) == 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom,
           TW'($urandom),
           $urandom);
    end
    idle(RL + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
